// File: rtl/ccsds_ldpc_pkg.sv
// Shared types and sizing helpers for the CCSDS LDPC frame arbiter slice.
package ccsds_ldpc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Never returns less than 1 so the result can always size a vector.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r_bits;
        r_bits = 0;
        while ((32'd1 << r_bits) < value) begin
            r_bits = r_bits + 1;
        end
        return (r_bits == 0) ? 1 : r_bits;
    endfunction

    function automatic int unsigned beats_in(input int unsigned k_bits, input int unsigned width);
        return k_bits / width;
    endfunction

endpackage

// File: rtl/ccsds_ldpc_id_fifo.sv
// Grant-ID FIFO: remembers which channel owns each frame inside the encoder.
module ccsds_ldpc_id_fifo
    import ccsds_ldpc_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ccsds_ldpc_frame_arbiter.sv
// Round-robin, frame-granular sharing of one LDPC encoder among CH_NUM streams;
// encoded frames are tagged with their source channel via a grant-ID FIFO.
module ccsds_ldpc_frame_arbiter
    import ccsds_ldpc_pkg::*;
#(
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned K_BITS   = 1024,
    parameter int unsigned ID_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM*WIDTH-1:0]  s_axis_tdata,
    input  logic [CH_NUM-1:0]        s_axis_tvalid,
    output logic [CH_NUM-1:0]        s_axis_tready,
    output logic [WIDTH-1:0]         enc_s_tdata,
    output logic                     enc_s_tvalid,
    input  logic                     enc_s_tready,
    input  logic [WIDTH-1:0]         enc_m_tdata,
    input  logic                     enc_m_tvalid,
    input  logic                     enc_m_tlast,
    output logic                     enc_m_tready,
    output logic [WIDTH-1:0]         m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic [clog2(CH_NUM)-1:0] m_axis_tdest,
    input  logic                     m_axis_tready,
    output logic                     err_orphan
);

    localparam int unsigned IDW      = clog2(CH_NUM);
    localparam int unsigned BEATS_IN = beats_in(K_BITS, WIDTH);
    localparam int unsigned CNTW     = clog2(BEATS_IN);

    state_t          r_state;
    state_t          w_state_d;
    logic [IDW-1:0]  r_grant_id;
    logic [IDW-1:0]  w_grant_id_d;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  w_rr_ptr_d;
    logic [CNTW-1:0] r_beat_cnt;
    logic [CNTW-1:0] w_beat_cnt_d;
    logic            r_err_orphan;
    logic [IDW-1:0]  w_winner;
    logic [IDW-1:0]  w_idx;
    logic            w_found;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;

    // First requester at or above rr_ptr, wrapping modulo CH_NUM.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            w_idx = IDW'((32'(r_rr_ptr) + i) % CH_NUM);
            if (!w_found && s_axis_tvalid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_grant_id_d  = r_grant_id;
        w_rr_ptr_d    = r_rr_ptr;
        w_beat_cnt_d  = r_beat_cnt;
        w_push        = 1'b0;
        enc_s_tdata   = '0;
        enc_s_tvalid  = 1'b0;
        s_axis_tready = '0;
        case (r_state)
            IDLE: begin
                if (w_found && !w_full) begin
                    w_push       = 1'b1;
                    w_grant_id_d = w_winner;
                    w_beat_cnt_d = '0;
                    w_state_d    = STREAM;
                end
            end
            STREAM: begin
                enc_s_tdata               = s_axis_tdata[32'(r_grant_id) * WIDTH +: WIDTH];
                enc_s_tvalid              = s_axis_tvalid[r_grant_id];
                s_axis_tready[r_grant_id] = enc_s_tready;
                if (enc_s_tvalid && enc_s_tready) begin
                    if (r_beat_cnt == CNTW'(BEATS_IN - 1)) begin
                        w_rr_ptr_d = (r_grant_id == IDW'(CH_NUM - 1)) ? '0
                                                                      : r_grant_id + IDW'(1);
                        w_state_d  = IDLE;
                    end else begin
                        w_beat_cnt_d = r_beat_cnt + CNTW'(1);
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_rr_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_grant_id <= w_grant_id_d;
            r_rr_ptr   <= w_rr_ptr_d;
            r_beat_cnt <= w_beat_cnt_d;
            if (enc_m_tvalid && w_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    // Output side is decoupled from the FSM; the FIFO head names the frame's owner.
    assign enc_m_tready  = m_axis_tready & ~w_empty;
    assign m_axis_tvalid = enc_m_tvalid & ~w_empty;
    assign m_axis_tdata  = enc_m_tdata;
    assign m_axis_tlast  = enc_m_tlast;
    assign w_pop         = enc_m_tvalid & enc_m_tready & enc_m_tlast;
    assign err_orphan    = r_err_orphan;

    ccsds_ldpc_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (ID_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_winner),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (m_axis_tdest)
    );

endmodule

// File: doc/ccsds_ldpc_frame_arbiter.md
Name: ccsds_ldpc_frame_arbiter

Overview:
- Shares one ccsds_ldpc_encoder instance between CH_NUM AXI-Stream information-bit sources.
- Grants the encoder input a whole frame at a time, using round-robin order.
- Tags every encoded output frame with the channel that produced it.
- Sits directly in front of, and directly behind, the encoder; the encoder's latency is tracked through a grant-ID FIFO.

Parameters:
- CH_NUM, 4, number of requesting channels (2..8).
- WIDTH, 8, stream data width; must match the encoder's width.
- K_BITS, 1024, information bits per frame. BEATS_IN = K_BITS/WIDTH (128 at defaults).
- ID_DEPTH, 4, depth of the grant-ID FIFO (power of 2). This is the maximum number of frames in flight inside the encoder.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  CH_NUM*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- s_axis_tvalid  in  CH_NUM  per-channel valid
- s_axis_tready  out  CH_NUM  per-channel ready
- enc_s_tdata  out  WIDTH  data to encoder
- enc_s_tvalid  out  1  valid to encoder
- enc_s_tready  in  1  encoder ready
- enc_m_tdata  in  WIDTH  encoded data
- enc_m_tvalid  in  1  encoded valid
- enc_m_tlast  in  1  encoded frame end
- enc_m_tready  out  1  ready to encoder
- m_axis_tdata  out  WIDTH  encoded data out
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output frame end
- m_axis_tdest  out  clog2(CH_NUM)  source channel of the current output frame
- m_axis_tready  in  1  downstream ready
- err_orphan  out  1  sticky flag: encoder output arrived with the ID FIFO empty

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; rr_ptr=0; beat_cnt=0; ID FIFO empty; err_orphan=0.
- Reset asserted mid-frame discards the partial frame and every queued ID. The encoder must be reset by the same rst.
- FSM states: IDLE and STREAM.
- IDLE:
  - A grant is made when any s_axis_tvalid bit is high and the ID FIFO is not full.
  - Winner: the first requesting channel searching upward from rst_ptr, wrapping modulo CH_NUM.
  - On the grant clock edge: register grant_id, push grant_id into the ID FIFO, set beat_cnt=0, go to STREAM.
  - If the ID FIFO is full, stay in IDLE and make no grant.
  - A grant takes effect in the cycle after the request is seen; no data is forwarded from IDLE.
- STREAM:
  - Combinational pass-through: enc_s_tdata/tvalid = selected channel's data/valid; s_axis_tready[grant_id] = enc_s_tready; all other s_axis_tready bits are 0.
  - beat_cnt increments on each enc_s_tvalid & enc_s_tready handshake.
  - Gaps in tvalid inside a frame are allowed and hold the grant.
  - On the handshake where beat_cnt==BEATS_IN-1: rr_ptr = grant_id+1 (wrapping), go to IDLE.
  - One idle input cycle between frames is permitted.
- Output side (independent of the FSM):
  - m_axis_tdata/tlast = enc_m_tdata/tlast.
  - m_axis_tvalid = enc_m_tvalid & fifo_nonempty.
  - enc_m_tready = m_axis_tready & fifo_nonempty.
  - m_axis_tdest = ID FIFO head.
  - Pop the FIFO on the enc_m_tvalid & enc_m_tready & enc_m_tlast handshake.
- Push and pop in the same cycle: both take effect, and the occupancy is unchanged. A pop frees a slot only on the following cycle for the full check.
- enc_m_tvalid while the FIFO is empty: enc_m_tready is held at 0 (the encoder stalls) and err_orphan is set. err_orphan clears only on rst.
- The ID FIFO never overflows by construction, because a full FIFO blocks grants.

Decomposition:
- Shared package ccsds_ldpc_pkg holds: the BEATS_IN derivation function, the clog2 function, and the FSM state encoding constants IDLE/STREAM.
- One sub-module: ccsds_ldpc_id_fifo, a synchronous FIFO of width clog2(CH_NUM) and depth ID_DEPTH with push, pop, full, empty and head ports.
- Expected size: about 200 RTL lines.

Test Plan:
- Single frame on channel 2 only (128 beats, data 0..127) -> encoder receives 128 beats in order; 160 output beats with tdest=2; tlast on beat 160; s_axis_tready[0,1,3] stay 0 throughout.
- Channels 0, 1 and 3 all continuously valid -> frame grant order 0,1,3,0; output tdest sequence 0,1,3,0, matching the reference-model encoded frames.
- m_axis_tready toggled 1-of-3 during output -> no beat lost or duplicated; tdest stays stable for the whole frame; enc_m_tready equals m_axis_tready.
- ID_DEPTH=2, encoder output held off (m_axis_tready=0), all channels valid -> exactly 2 grants, then stuck in IDLE with all s_axis_tready 0; releasing m_axis_tready allows the 3rd grant one cycle after the first pop.
- rst pulsed at input beat 60 of a frame on channel 1 -> all outputs 0 and FIFO empty; the next frame is granted to channel 0 (rr_ptr=0) and encodes correctly.
- Forced enc_m_tvalid=1 with no frame granted -> enc_m_tready=0, m_axis_tvalid=0, err_orphan=1, which persists until rst.
